spi_slave_interface: RTL and testbench

SPI responder (mode 0, MSB first) that receives DATA-bit words on `mosi` and pushes them into a receive FIFO, while returning words popped from a transmit FIFO on `miso`. It is the far end of our SPI master and attaches to a show-ahead FIFO pair on the system side. All SPI pins are treated as asynchronous and oversampled by the single system clock.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_slave_interface_sync.sv | 39 +++
 rtl/spi_slave_interface.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave_interface.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_WAIT_DESEL = 2'd3
    } slave_state_type;

    localparam int SYNC_STAGES = 2;
    localparam int DATA_W      = 8;

endpackage

// File: rtl/spi_slave_interface_sync.sv
// Pin synchronizer with rise/fall pulse generation for one SPI input.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE}};
            dly_q  <= IDLE;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~dly_q;
    assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-0 responder bridging an RX/TX show-ahead FIFO pair.
module spi_slave_interface
    import spi_pkg::*;
#(
    parameter int              DATA = DATA_W,
    parameter logic [DATA-1:0] FILL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scsn,
    input  logic            sclk,
    input  logic            mosi,
    output logic            miso,
    output logic [DATA-1:0] wdata,
    output logic            wr,
    input  logic            full,
    input  logic [DATA-1:0] rdata,
    output logic            rd,
    input  logic            empty,
    input  logic            clr_flags,
    output logic            busy,
    output logic            overrun,
    output logic            underrun,
    output logic [15:0]     rx_count
);

    localparam int CW = $clog2(DATA + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic scsn_s, scsn_rise, scsn_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_pins;

    spi_sync_edge #(.IDLE(1'b1)) u_scsn (
        .clk(clk), .rst(rst), .din(scsn),
        .dout(scsn_s), .rise(scsn_rise), .fall(scsn_fall)
    );
    spi_sync_edge #(.IDLE(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.IDLE(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_pins = ^{sclk_s, mosi_rise, mosi_fall};

    slave_state_type state_q, state_d;
    logic [DATA-1:0] tx_q, tx_d;
    logic [DATA-1:0] rx_q, rx_d;
    logic [DATA-1:0] wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [15:0]     rxc_q, rxc_d;
    logic pend_q, pend_d;
    logic wr_q, wr_d;
    logic rd_q, rd_d;
    logic busy_q, busy_d;
    logic ovr_q, ovr_d;
    logic und_q, und_d;
    logic load, ovr_set, und_set;

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        rxc_d    = rxc_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        load     = 1'b0;
        ovr_set  = 1'b0;
        und_set  = 1'b0;

        // Synchronized scsn is meaningless until the pipeline has refilled.
        if (settle_q != SW'(SYNC_STAGES))
            settle_d = settle_q + SW'(1);

        if (state_q != ST_IDLE && scsn_rise) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (scsn_fall) begin
                        state_d = ST_LOAD;
                        rxc_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_d = {rx_q[DATA-2:0], mosi_s};
                        if (cnt_q == CW'(DATA - 1)) begin
                            cnt_d   = '0;
                            pend_d  = 1'b1;
                            wdata_d = rx_d;
                            if (!full) begin
                                wr_d = 1'b1;
                                if (rxc_q != 16'hFFFF)
                                    rxc_d = rxc_q + 16'd1;
                            end else begin
                                ovr_set = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (pend_q) begin
                            load   = 1'b1;
                            pend_d = 1'b0;
                        end else begin
                            tx_d = {tx_q[DATA-2:0], 1'b0};
                        end
                    end
                end
                ST_WAIT_DESEL: begin
                    if (settle_q == SW'(SYNC_STAGES) && scsn_s)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load) begin
            if (!empty) begin
                tx_d = rdata;
                rd_d = 1'b1;
            end else begin
                tx_d    = FILL;
                und_set = 1'b1;
            end
        end

        ovr_d = ovr_set | (ovr_q & ~clr_flags);
        und_d = und_set | (und_q & ~clr_flags);
    end

    // Reset parks in WAIT_DESEL so a frame already in flight is never joined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_WAIT_DESEL;
            tx_q     <= '0;
            rx_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            rxc_q    <= '0;
            pend_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            rxc_q    <= rxc_d;
            pend_q   <= pend_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
        end
    end

    assign miso     = (state_q == ST_SHIFT) & tx_q[DATA-1];
    assign wdata    = wdata_q;
    assign wr       = wr_q;
    assign rd       = rd_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;
    assign underrun = und_q;
    assign rx_count = rxc_q;

endmodule

// File: tb/tb_spi_slave_interface.sv
// Bench: SPI master model, show-ahead TX FIFO model and RX scoreboard.
module tb_spi_slave_interface;
    import spi_pkg::*;

    localparam int         H     = 60;
    localparam logic [7:0] FILLV = 8'h00;

    logic        clk = 1'b0;
    logic        rst, scsn, sclk, mosi, miso;
    logic        wr, full, rd, empty, clr_flags;
    logic        busy, overrun, underrun;
    logic [7:0]  wdata, rdata;
    logic [15:0] rx_count;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;

    logic [7:0] txq[$];
    logic [7:0] exp_wr[$];
    logic [7:0] mw[8];
    logic       fp[8];
    logic       m_ovr = 1'b0;
    logic       m_und = 1'b0;

    always #5 clk = ~clk;

    spi_slave_interface #(.DATA(8), .FILL(FILLV)) dut (
        .clk(clk), .rst(rst), .scsn(scsn), .sclk(sclk), .mosi(mosi),
        .miso(miso), .wdata(wdata), .wr(wr), .full(full),
        .rdata(rdata), .rd(rd), .empty(empty), .clr_flags(clr_flags),
        .busy(busy), .overrun(overrun), .underrun(underrun),
        .rx_count(rx_count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // TX FIFO model plus RX scoreboard monitor.
    always @(negedge clk) begin : mon_p
        logic [7:0] e;
        if (rd) begin
            rd_cnt++;
            if (txq.size() > 0) txq.delete(0);
        end
        empty = (txq.size() == 0);
        rdata = empty ? 8'h00 : txq[0];
        if (wr) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got wdata %0h want no wr", wdata);
            end else begin
                e = exp_wr.pop_front();
                if (wdata !== e) begin
                    bad++;
                    $display("FAIL wdata: got %0h want %0h", wdata, e);
                end
            end
        end
    end

    task automatic run_frame(input int n, input int abort_bits);
        logic [7:0] snap[$];
        logic [7:0] expm, got;
        int loads, rd0, exp_rx, nb, er, k;
        snap   = txq;
        rd0    = rd_cnt;
        exp_rx = 0;
        loads  = (abort_bits > 0) ? 1 : n + 1;
        nb     = (abort_bits > 0) ? abort_bits : 8;
        full   = fp[0];
        scsn   = 1'b0;
        mosi   = mw[0][7];
        #100;
        chk("busy_frame", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            expm = (i < snap.size()) ? snap[i] : FILLV;
            full = fp[i];
            if (abort_bits == 0) begin
                if (!fp[i]) begin
                    exp_wr.push_back(mw[i]);
                    exp_rx++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            got = 8'h00;
            for (int b = 0; b < nb; b++) begin
                mosi = mw[i][7-b];
                #H;
                sclk = 1'b1;
                got  = {got[6:0], miso};
                #H;
                sclk = 1'b0;
            end
            if (abort_bits == 0)
                chk($sformatf("miso_w%0d", i), 32'(got), 32'(expm));
        end
        if (snap.size() < loads) m_und = 1'b1;
        #H;
        full = 1'b0;
        scsn = 1'b1;
        for (k = 0; k < 8 && busy; k++) @(negedge clk);
        chk("busy_drop", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        er = (loads < snap.size()) ? loads : snap.size();
        chk("rd_count", 32'(rd_cnt - rd0), 32'(er));
        chk("rx_count", 32'(rx_count), 32'(exp_rx));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("wr_missing", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        @(negedge clk);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_underrun", 32'(underrun), 32'd0);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 8; i++) begin
            mw[i] = 8'($urandom);
            fp[i] = 1'b0;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; scsn = 1'b1; sclk = 1'b0; mosi = 1'b0;
        full = 1'b0; clr_flags = 1'b0; empty = 1'b1; rdata = 8'h00;
        #23;
        chk_reset_outs();
        #20 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("state_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Single word
        clear_pat();
        mw[0] = 8'hA5;
        txq.push_back(8'h3C);
        repeat (2) @(negedge clk);
        run_frame(1, 0);

        // Three words
        clear_pat();
        mw[0] = 8'h01; mw[1] = 8'h80; mw[2] = 8'hFF;
        txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33);
        repeat (2) @(negedge clk);
        run_frame(3, 0);
        do_clr();

        // Empty TX FIFO sends FILL
        clear_pat();
        repeat (2) @(negedge clk);
        run_frame(1, 0);
        do_clr();

        // RX FIFO full on the second word
        clear_pat();
        fp[1] = 1'b1;
        txq.push_back(8'h44); txq.push_back(8'h55); txq.push_back(8'h66);
        repeat (2) @(negedge clk);
        run_frame(2, 0);
        do_clr();

        // Deselect after 5 bits, then a clean frame
        clear_pat();
        txq.push_back(8'h99);
        repeat (2) @(negedge clk);
        run_frame(1, 5);
        clear_pat();
        mw[0] = 8'h5A;
        txq.push_back(8'h77); txq.push_back(8'h66);
        repeat (2) @(negedge clk);
        run_frame(1, 0);
        do_clr();

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            int n, nt;
            n  = $urandom_range(1, 3);
            nt = $urandom_range(0, 4);
            for (int i = 0; i < nt; i++) txq.push_back(8'($urandom));
            for (int i = 0; i < 8; i++) begin
                mw[i] = 8'($urandom);
                fp[i] = ($urandom_range(0, 3) == 0);
            end
            repeat (2) @(negedge clk);
            run_frame(n, 0);
            if (f % 2 == 1) do_clr();
        end

        // Reset in the middle of a word, released while selected
        txq.delete();
        txq.push_back(8'hE7);
        repeat (2) @(negedge clk);
        scsn = 1'b0;
        mosi = 1'b1;
        #100;
        for (int b = 0; b < 4; b++) begin
            mosi = b[0];
            #H sclk = 1'b1;
            #H sclk = 1'b0;
        end
        #20 rst = 1'b1;
        #20;
        chk_reset_outs();
        rst = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        repeat (6) @(negedge clk);
        chk("state_wait_desel", 32'(dut.state_q), 32'(ST_WAIT_DESEL));
        for (int b = 0; b < 12; b++) begin
            mosi = 1'($urandom);
            #H sclk = 1'b1;
            #H sclk = 1'b0;
        end
        chk("desel_busy", 32'(busy), 32'd0);
        chk("desel_rx_count", 32'(rx_count), 32'd0);
        scsn = 1'b1;
        repeat (10) @(negedge clk);
        chk("state_after_desel", 32'(dut.state_q), 32'(ST_IDLE));
        clear_pat();
        mw[0] = 8'hC3;
        txq.push_back(8'h4B);
        repeat (2) @(negedge clk);
        run_frame(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
